// File: rtl/idx_seq_pkg.sv
// Shared types and constants for the round-robin index sequencer.
// Sizes, FSM state encoding and the index type used across the block.
package idx_seq_pkg;

   localparam int unsigned WIDTH = 128;
   localparam int unsigned IDX_W = 7;

   typedef logic [IDX_W-1:0] idx_t;

   typedef enum logic {
      IDLE,
      ISSUE
   } state_e;

endpackage

// File: rtl/rr_find_first128.sv
// Circular find-first-set over a 128-bit vector, starting at a given position.
// Bits at or above start take priority; otherwise the search wraps to bit 0.
module rr_find_first128
   import idx_seq_pkg::*;
(
   input  logic [WIDTH-1:0] vector,
   input  idx_t             start,
   output logic             found,
   output idx_t             index,
   output logic [WIDTH-1:0] onehot
);

   logic [WIDTH-1:0] hi_part;
   logic [WIDTH-1:0] search;

   always_comb begin
      hi_part = vector & ({WIDTH{1'b1}} << start);
      search  = (|hi_part) ? hi_part : vector;
      found   = |vector;
      // Isolate the lowest set bit of the selected half.
      onehot  = search & ~(search - {{(WIDTH-1){1'b0}}, 1'b1});
      index   = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (search[i]) begin
            index = idx_t'(i);
         end
      end
   end

endmodule

// File: rtl/idx_rr_sequencer128.sv
// Stores a 128-bit request vector and issues the index of each set bit, one per
// handshake, in circular order starting just after the last index issued.
module idx_rr_sequencer128
   import idx_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 128,
   parameter int unsigned IDX_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_vec,
   output logic             idx_valid,
   input  logic             idx_ready,
   output logic [IDX_W-1:0] idx,
   output logic             idx_last,
   output logic             busy
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pending_q, pending_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             last_q, last_d;

   logic [WIDTH-1:0] find_vec;
   logic [IDX_W-1:0] find_start;
   logic             find_found;
   logic [IDX_W-1:0] find_idx;
   logic [WIDTH-1:0] find_onehot;
   logic [WIDTH-1:0] remain;
   logic [IDX_W-1:0] idx_inc;

   // One shared search: the incoming vector when idle, the leftovers while issuing.
   always_comb begin
      idx_inc    = idx_q + 1'b1;
      find_vec   = (state_q == ISSUE) ? pending_q : req_vec;
      find_start = (state_q == ISSUE) ? idx_inc : ptr_q;
      remain     = find_vec & ~find_onehot;
   end

   rr_find_first128 u_find (
      .vector (find_vec),
      .start  (find_start),
      .found  (find_found),
      .index  (find_idx),
      .onehot (find_onehot)
   );

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      ptr_d     = ptr_q;
      idx_d     = idx_q;
      last_d    = last_q;
      unique case (state_q)
         IDLE: begin
            // An all-zero vector is accepted but produces nothing.
            if (req_valid && find_found) begin
               state_d   = ISSUE;
               idx_d     = find_idx;
               pending_d = remain;
               last_d    = ~|remain;
            end
         end
         ISSUE: begin
            if (idx_ready) begin
               ptr_d = idx_inc;
               if (last_q) begin
                  state_d = IDLE;
                  last_d  = 1'b0;
               end else begin
                  idx_d     = find_idx;
                  pending_d = remain;
                  last_d    = ~|remain;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= '0;
         ptr_q     <= '0;
         idx_q     <= '0;
         last_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         ptr_q     <= ptr_d;
         idx_q     <= idx_d;
         last_q    <= last_d;
      end
   end

   always_comb begin
      req_ready = (state_q == IDLE) && !rst;
      idx_valid = (state_q == ISSUE);
      busy      = (state_q == ISSUE);
      idx       = idx_q;
      idx_last  = last_q;
   end

endmodule

// File: tb/tb_idx_rr_sequencer128.sv
// Directed, table-driven bench for idx_rr_sequencer128 with hand-computed
// expected values, plus hand-written reset and full-vector sequences.
module tb_idx_rr_sequencer128;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid;
   logic         req_ready;
   logic [127:0] req_vec;
   logic         idx_valid;
   logic         idx_ready;
   logic [6:0]   idx;
   logic         idx_last;
   logic         busy;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   idx_rr_sequencer128 dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_vec   (req_vec),
      .idx_valid (idx_valid),
      .idx_ready (idx_ready),
      .idx       (idx),
      .idx_last  (idx_last),
      .busy      (busy)
   );

   typedef struct {
      logic         rv;
      logic [127:0] vec;
      logic         ir;
      logic         rr;
      logic         iv;
      logic [6:0]   idx;
      logic         last;
      logic [6:0]   ptr;
   } row_t;

   row_t tv[21];

   function automatic logic [127:0] b(int i);
      logic [127:0] one;
      one = 128'h1;
      return one << i;
   endfunction

   function automatic row_t mk(logic rv, logic [127:0] vec, logic ir, logic rr, logic iv,
                               int ix, logic last, int ptr);
      row_t r;
      r.rv   = rv;
      r.vec  = vec;
      r.ir   = ir;
      r.rr   = rr;
      r.iv   = iv;
      r.idx  = 7'(ix);
      r.last = last;
      r.ptr  = 7'(ptr);
      return r;
   endfunction

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(logic r, logic rv, logic [127:0] vec, logic ir);
      rst       = r;
      req_valid = rv;
      req_vec   = vec;
      idx_ready = ir;
   endtask

   initial begin
      tv[0]  = mk(1, b(0), 1, 1, 0, 0, 0, 0);
      tv[1]  = mk(0, '0, 1, 0, 1, 0, 1, 0);
      tv[2]  = mk(0, '0, 1, 1, 0, 0, 0, 1);
      tv[3]  = mk(1, b(3) | b(64) | b(127), 1, 1, 0, 0, 0, 1);
      tv[4]  = mk(0, '0, 1, 0, 1, 3, 0, 1);
      tv[5]  = mk(0, '0, 1, 0, 1, 64, 0, 4);
      tv[6]  = mk(0, '0, 1, 0, 1, 127, 1, 65);
      tv[7]  = mk(0, '0, 1, 1, 0, 0, 0, 0);
      tv[8]  = mk(1, b(64), 1, 1, 0, 0, 0, 0);
      tv[9]  = mk(0, '0, 1, 0, 1, 64, 1, 0);
      tv[10] = mk(1, b(10) | b(100), 1, 1, 0, 0, 0, 65);
      tv[11] = mk(1, b(50), 1, 0, 1, 100, 0, 65);
      tv[12] = mk(0, '0, 1, 0, 1, 10, 1, 101);
      tv[13] = mk(1, b(5) | b(6), 0, 1, 0, 0, 0, 11);
      tv[14] = mk(0, '0, 0, 0, 1, 5, 0, 11);
      tv[15] = mk(0, '0, 0, 0, 1, 5, 0, 11);
      tv[16] = mk(0, '0, 0, 0, 1, 5, 0, 11);
      tv[17] = mk(0, '0, 1, 0, 1, 5, 0, 11);
      tv[18] = mk(0, '0, 1, 0, 1, 6, 1, 6);
      tv[19] = mk(1, '0, 1, 1, 0, 0, 0, 7);
      tv[20] = mk(0, '0, 1, 1, 0, 0, 0, 7);

      // Reset
      drive(1, 0, '0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_req_ready", 128'(req_ready), 128'(0));
      chk("rst_idx_valid", 128'(idx_valid), 128'(0));
      chk("rst_idx", 128'(idx), 128'(0));
      chk("rst_idx_last", 128'(idx_last), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_ptr", 128'(dut.ptr_q), 128'(0));

      // Table: inputs for the cycle, then the outputs expected in that cycle
      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         drive(0, tv[i].rv, tv[i].vec, tv[i].ir);
         #1;
         chk($sformatf("row%0d_req_ready", i), 128'(req_ready), 128'(tv[i].rr));
         chk($sformatf("row%0d_idx_valid", i), 128'(idx_valid), 128'(tv[i].iv));
         chk($sformatf("row%0d_busy", i), 128'(busy), 128'(tv[i].iv));
         chk($sformatf("row%0d_ptr", i), 128'(dut.ptr_q), 128'(tv[i].ptr));
         if (tv[i].iv) begin
            chk($sformatf("row%0d_idx", i), 128'(idx), 128'(tv[i].idx));
            chk($sformatf("row%0d_idx_last", i), 128'(idx_last), 128'(tv[i].last));
         end
      end

      // Reset in the middle of a 4-bit batch {20,30,40,50}, ptr starts at 7
      @(negedge clk);
      drive(0, 1, b(20) | b(30) | b(40) | b(50), 1);
      @(negedge clk);
      drive(0, 0, '0, 1);
      #1;
      chk("mid_idx0", 128'(idx), 128'(20));
      @(negedge clk);
      #1;
      chk("mid_idx1", 128'(idx), 128'(30));
      @(negedge clk);
      drive(1, 0, '0, 1);
      #1;
      chk("mid_idx2", 128'(idx), 128'(40));
      chk("mid_rst_req_ready", 128'(req_ready), 128'(0));
      @(negedge clk);
      drive(0, 1, b(1), 1);
      #1;
      chk("mid_after_valid", 128'(idx_valid), 128'(0));
      chk("mid_after_idx", 128'(idx), 128'(0));
      chk("mid_after_last", 128'(idx_last), 128'(0));
      chk("mid_after_busy", 128'(busy), 128'(0));
      chk("mid_after_ptr", 128'(dut.ptr_q), 128'(0));
      chk("mid_after_req_ready", 128'(req_ready), 128'(1));
      @(negedge clk);
      drive(0, 0, '0, 1);
      #1;
      chk("new_idx", 128'(idx), 128'(1));
      chk("new_last", 128'(idx_last), 128'(1));
      chk("new_valid", 128'(idx_valid), 128'(1));
      @(negedge clk);
      #1;
      chk("new_done_valid", 128'(idx_valid), 128'(0));
      chk("new_done_ptr", 128'(dut.ptr_q), 128'(2));

      // All-ones vector from ptr=0
      drive(1, 0, '0, 1);
      @(negedge clk);
      drive(0, 1, {128{1'b1}}, 1);
      #1;
      chk("ones_ptr0", 128'(dut.ptr_q), 128'(0));
      for (int i = 0; i < 128; i++) begin
         @(negedge clk);
         drive(0, 0, '0, 1);
         #1;
         chk($sformatf("ones_valid%0d", i), 128'(idx_valid), 128'(1));
         chk($sformatf("ones_idx%0d", i), 128'(idx), 128'(i));
         chk($sformatf("ones_last%0d", i), 128'(idx_last), 128'(i == 127));
      end
      @(negedge clk);
      #1;
      chk("ones_done_valid", 128'(idx_valid), 128'(0));
      chk("ones_done_req_ready", 128'(req_ready), 128'(1));
      chk("ones_done_ptr", 128'(dut.ptr_q), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/idx_rr_sequencer128.md
# idx_rr_sequencer128

Round-robin index sequencer that sits directly upstream of the 7-to-128 one-hot decoder. It accepts a 128-bit request vector, stores it, and emits the index of each set bit as a 7-bit code, one per cycle under a valid/ready handshake. The search order is circular and starts just after the last index issued. Each emitted code drives the decoder's 7-bit select input.

## Interface
- `WIDTH`, default 128: request vector width; fixed at 128 for this block.
- `IDX_W`, default 7: index width; equals clog2(WIDTH).
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: `req_vec` is presented.
- `req_ready`  out  1: block can accept a new vector.
- `req_vec`  in  128: request bits; bit n requests index n.
- `idx_valid`  out  1: `idx` holds a pending index.
- `idx_ready`  in  1: downstream consumes `idx`.
- `idx`  out  7: index of the current granted bit.
- `idx_last`  out  1: `idx` is the final set bit of the current batch.
- `busy`  out  1: a batch is in progress (state ISSUE).

## Operation
- States:
  - IDLE: `req_ready`=1 (0 while `rst`=1).
  - ISSUE: `req_ready`=0, `idx_valid`=1.
- Registers:
  - `pending[127:0]`: bits of the batch not yet issued.
  - `ptr[6:0]`: next search start position.
  - `idx`, `idx_last`: registered outputs.
- IDLE → ISSUE on `req_valid`&&`req_ready` with a nonzero `req_vec`:
  - `pending` ← `req_vec` with the found bit cleared.
  - `idx` ← first set bit at or above `ptr`, searching circularly (127 wraps to 0).
  - `idx_last` ← 1 if `req_vec` has exactly that one bit set.
- Zero `req_vec` is accepted and dropped. No index is produced, and the block stays in IDLE.
- In ISSUE, when `idx_valid`&&`idx_ready`:
  - `ptr` ← `idx`+1 (mod 128).
  - If `idx_last`=1: go to IDLE and clear `idx_valid`.
  - Otherwise: `idx` ← circular-first set bit of `pending` starting at `idx`+1, `pending` clears that bit, and `idx_last` is recomputed (1 when the new `pending` is zero).
- With `idx_valid`=1 and `idx_ready`=0: `idx`, `idx_last`, `pending` and `ptr` all hold unchanged.
- `ptr` persists across batches to give round-robin fairness. Only reset returns it to 0.
- No input is accepted in ISSUE. `req_vec` is sampled only on the accept edge.

## Timing
- Reset values: `idx_valid`=0, `idx`=0, `idx_last`=0, `busy`=0, `pending`=0, `ptr`=0, state=IDLE. `req_ready`=0 during the `rst` cycle and 1 on the first cycle after it.
- Latency: a vector accepted at edge N gives `idx_valid`=1 after edge N (first index visible in cycle N+1).
- Throughput: one index per cycle while `idx_ready`=1. A batch of k bits completes in k handshake cycles.
- After the handshake of the last index at edge M: `idx_valid`=0 and `req_ready`=1 in cycle M+1. A new accept is possible at edge M+1, so the accept-to-accept gap is k+1 cycles.
- `rst` mid-batch: all state returns to reset values at that edge. Remaining `pending` bits are discarded.
- The circular search is combinational over 128 bits and must close timing in one cycle.

## Structure
- Shared package `idx_seq_pkg`:
  - `WIDTH`=128 and `IDX_W`=7.
  - State enum {IDLE, ISSUE}.
  - `idx_t` typedef (logic [6:0]).
- Sub-module `rr_find_first128`:
  - Inputs: vector[127:0], start[6:0].
  - Outputs: found, index[6:0], onehot[127:0].
  - Implementation: priority search on the vector rotated by `start`, or a doubled vector masked by `start`.
  - The sequencer instantiates it once, on a mux of `req_vec` (IDLE) or `pending` (ISSUE) with start `ptr` (IDLE) or `idx`+1 (ISSUE).

## Test plan
- Reset, then `req_vec`=128'h1 with `idx_ready`=1 → cycle after accept: `idx`=0, `idx_valid`=1, `idx_last`=1. Next cycle: `req_ready`=1, `ptr`=1.
- After reset, bits {3,64,127} with `idx_ready`=1 → `idx` 3, 64, 127 on consecutive cycles, `idx_last` only on 127, then `ptr`=0.
- Round-robin: after a batch ending at 64 (`ptr`=65), send bits {10,100} → order 100 then 10. `idx_last` on 10.
- Backpressure: bits {5,6}, hold `idx_ready`=0 for 3 cycles → `idx`=5 and `idx_valid`=1 stable for 3 cycles. Then 5, then 6.
- `req_vec`=0 accepted → `idx_valid` never asserts and `req_ready` stays 1. All-ones vector from `ptr`=0 → `idx` 0..127 on 128 consecutive cycles, `idx_last` at 127.
- Assert `rst` after 2 of 4 indices issued → next cycle: all outputs at reset values, `ptr`=0. A new vector {1} yields `idx`=1.
